// File: rtl/board_painter_pkg.sv
// Shared geometry, colour width and sweep-FSM encodings for the board painter slice.
package board_painter_pkg;

    localparam int CELL_W     = 64;
    localparam int CELL_H     = 24;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int RGB_W      = 9;
    localparam int X_W        = 4;
    localparam int Y_W        = 5;
    localparam int PX_W       = 10;
    localparam int PY_W       = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WAIT   = 3'd2,
        LAUNCH = 3'd3,
        DRAW   = 3'd4,
        NEXT   = 3'd5
    } state_t;

endpackage

// File: rtl/board_painter_cell_to_pixel.sv
// Cell coordinate to pixel origin: x*64 as a shift, y*24 as y*16 + y*8.
module cell_to_pixel
    import board_painter_pkg::*;
(
    input  logic [X_W-1:0]  cell_x,
    input  logic [Y_W-1:0]  cell_y,
    output logic [PX_W-1:0] pix_x,
    output logic [PY_W-1:0] pix_y
);

    localparam int X_SHIFT = $clog2(CELL_W);

    always_comb begin
        pix_x = PX_W'(cell_x) << X_SHIFT;
        pix_y = (PY_W'(cell_y) << 4) + (PY_W'(cell_y) << 3);
    end

endmodule

// File: rtl/board_painter.sv
// Sweeps the board in raster order, reads each cell's occupancy and issues one
// renderer box draw per cell, overlaying the active piece.
module board_painter
    import board_painter_pkg::*;
#(
    parameter int               COLS     = BOARD_COLS,
    parameter int               ROWS     = BOARD_ROWS,
    parameter logic [RGB_W-1:0] FG_COLOR = 9'b111_000_111,
    parameter logic [RGB_W-1:0] BG_COLOR = 9'b000_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              req,
    input  logic              blank,
    input  logic [X_W-1:0]    cur_x,
    input  logic [Y_W-1:0]    cur_y,
    input  logic [RGB_W-1:0]  piece_color,
    output logic [X_W-1:0]    board_rx,
    output logic [Y_W-1:0]    board_ry,
    input  logic              board_rdata,
    output logic              start,
    output logic [PX_W-1:0]   x0,
    output logic [PY_W-1:0]   y0,
    output logic [RGB_W-1:0]  color,
    input  logic              busy,
    input  logic              done,
    output logic              sweeping,
    output logic              frame_done
);

    localparam logic [X_W-1:0] LAST_X = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(ROWS - 1);

    state_t             state, state_nxt;
    logic [X_W-1:0]     cell_x, snap_x;
    logic [Y_W-1:0]     cell_y, snap_y;
    logic [RGB_W-1:0]   snap_color, cell_color;
    logic               snap_blank, pending;
    logic [PX_W-1:0]    pix_x;
    logic [PY_W-1:0]    pix_y;
    logic               begin_sweep, load_cell, fire, advance, end_sweep;
    logic               last_col, last_cell;

    cell_to_pixel u_cell_to_pixel (
        .cell_x (cell_x),
        .cell_y (cell_y),
        .pix_x  (pix_x),
        .pix_y  (pix_y)
    );

    // The RAM address is simply the live cell counter.
    assign board_rx  = cell_x;
    assign board_ry  = cell_y;
    assign last_col  = (cell_x == LAST_X);
    assign last_cell = last_col && (cell_y == LAST_Y);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req || pending) state_nxt = ADDR;
            ADDR:    state_nxt = WAIT;
            WAIT:    state_nxt = LAUNCH;
            LAUNCH:  if (!busy) state_nxt = DRAW;
            DRAW:    if (done) state_nxt = NEXT;
            NEXT:    state_nxt = last_cell ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        begin_sweep = (state == IDLE) && (req || pending);
        load_cell   = (state == WAIT);
        fire        = (state == LAUNCH) && !busy;
        advance     = (state == NEXT);
        end_sweep   = advance && last_cell;
        // Blank beats the piece overlay, which beats board occupancy.
        if (snap_blank)                                 cell_color = BG_COLOR;
        else if (cell_x == snap_x && cell_y == snap_y)  cell_color = snap_color;
        else if (board_rdata)                           cell_color = FG_COLOR;
        else                                            cell_color = BG_COLOR;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cell_x     <= '0;
            cell_y     <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_color <= '0;
            snap_blank <= 1'b0;
            pending    <= 1'b0;
            sweeping   <= 1'b0;
            frame_done <= 1'b0;
            start      <= 1'b0;
            x0         <= '0;
            y0         <= '0;
            color      <= '0;
        end else begin
            start      <= fire;
            frame_done <= end_sweep;
            if (begin_sweep) begin
                cell_x     <= '0;
                cell_y     <= '0;
                snap_x     <= cur_x;
                snap_y     <= cur_y;
                snap_color <= piece_color;
                snap_blank <= blank;
                sweeping   <= 1'b1;
                pending    <= 1'b0;
            end else begin
                if (req && state != IDLE) pending <= 1'b1;
                if (end_sweep)            sweeping <= 1'b0;
            end
            // Box parameters only change here, so they hold from start until done.
            if (load_cell) begin
                x0    <= pix_x;
                y0    <= pix_y;
                color <= cell_color;
            end
            if (advance) begin
                if (last_col) begin
                    cell_x <= '0;
                    cell_y <= last_cell ? '0 : cell_y + 5'd1;
                end else begin
                    cell_x <= cell_x + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_painter.sv
// Self-checking bench for board_painter: renderer/RAM models, per-draw scoreboard, probe table.
module tb_board_painter;

    localparam logic [8:0] FG = 9'h1C7;
    localparam logic [8:0] BG = 9'h000;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       blank = 1'b0;
    logic [3:0] cur_x = '0;
    logic [4:0] cur_y = '0;
    logic [8:0] piece_color = '0;
    logic [3:0] board_rx;
    logic [4:0] board_ry;
    logic       board_rdata = 1'b0;
    logic       start;
    logic [9:0] x0;
    logic [8:0] y0;
    logic [8:0] color;
    logic       busy, done, sweeping, frame_done;
    logic       rbusy = 1'b0, rdone = 1'b0, busy_hold = 1'b0, spur_done = 1'b0;

    assign busy = rbusy | busy_hold;
    assign done = rdone | spur_done;

    board_painter dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .req         (req),
        .blank       (blank),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .piece_color (piece_color),
        .board_rx    (board_rx),
        .board_ry    (board_ry),
        .board_rdata (board_rdata),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .color       (color),
        .busy        (busy),
        .done        (done),
        .sweeping    (sweeping),
        .frame_done  (frame_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    bit occ [0:9][0:19];
    always @(posedge CLOCK_50)
        board_rdata <= (board_rx < 4'd10 && board_ry < 5'd20) ? occ[board_rx][board_ry] : 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          total_starts = 0;
    int          frames = 0;
    int          draw_idx = 0;
    int          rcnt = 0;
    logic [27:0] exp_q[$];
    logic [27:0] cap [0:199];
    logic [27:0] inflight = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic logic [8:0] model_color(bit bl, int x, int y, int px, int py,
                                               logic [8:0] pc, bit o);
        if (bl) return BG;
        if (x == px && y == py) return pc;
        return o ? FG : BG;
    endfunction

    // Expected draw list of one full sweep, from the inputs as they stand now.
    task automatic push_sweep();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                exp_q.push_back({10'(x * 64), 9'(y * 24),
                                 model_color(blank, x, y, int'(cur_x), int'(cur_y),
                                             piece_color, occ[x][y])});
    endtask

    // Draw scoreboard and renderer model (done three cycles after start).
    always @(negedge CLOCK_50) begin
        if (reset) begin
            draw_idx = 0;
            rbusy    = 1'b0;
            rdone    = 1'b0;
            rcnt     = 0;
        end else begin
            if (start) begin
                check("start_busy_low", {31'd0, busy}, 32'd0);
                if (exp_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
                else                   check("draw", {4'd0, x0, y0, color}, {4'd0, exp_q.pop_front()});
                if (draw_idx < 200) cap[draw_idx] = {x0, y0, color};
                draw_idx++;
                total_starts++;
                inflight = {x0, y0, color};
            end
            if (frame_done) begin
                frames++;
                draw_idx = 0;
            end
            rdone = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    rdone = 1'b1;
                    rbusy = 1'b0;
                    check("hold_until_done", {4'd0, x0, y0, color}, {4'd0, inflight});
                end
            end
            if (start) begin
                rbusy = 1'b1;
                rcnt  = 3;
            end
        end
    end

    task automatic pulse_req();
        @(posedge CLOCK_50); #2 req = 1'b1;
        @(posedge CLOCK_50); #2 req = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        bit found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge CLOCK_50);
            if (frame_done) found = 1'b1;
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, {31'd0, start}, 32'd0);
        check({tag, "_sweeping"}, {31'd0, sweeping}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_x0"}, {22'd0, x0}, 32'd0);
        check({tag, "_y0"}, {23'd0, y0}, 32'd0);
        check({tag, "_color"}, {23'd0, color}, 32'd0);
        check({tag, "_board_rx"}, {28'd0, board_rx}, 32'd0);
        check({tag, "_board_ry"}, {27'd0, board_ry}, 32'd0);
    endtask

    task automatic set_board(input bit fill, input bit corner);
        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 20; y++)
                occ[x][y] = fill;
        if (corner) occ[9][19] = 1'b1;
    endtask

    typedef struct {
        bit         bl;
        bit         fill;
        bit         corner;
        logic [3:0] px;
        logic [4:0] py;
        logic [8:0] pc;
        int         cx;
        int         cy;
        logic [9:0] ex0;
        logic [8:0] ey0;
        logic [8:0] ecol;
    } vec_t;

    vec_t vt [9];

    initial begin
        int base, frames0, stray;
        bit found;

        vt[0] = '{1'b0, 1'b0, 1'b1, 4'd3, 5'd5,  9'h1C7, 9, 19, 10'd576, 9'd456, FG};
        vt[1] = '{1'b0, 1'b0, 1'b1, 4'd3, 5'd5,  9'h1C7, 3, 5,  10'd192, 9'd120, 9'h1C7};
        vt[2] = '{1'b0, 1'b0, 1'b1, 4'd3, 5'd5,  9'h1C7, 0, 0,  10'd0,   9'd0,   BG};
        vt[3] = '{1'b1, 1'b1, 1'b1, 4'd3, 5'd5,  9'h0AB, 9, 19, 10'd576, 9'd456, BG};
        vt[4] = '{1'b1, 1'b1, 1'b1, 4'd3, 5'd5,  9'h0AB, 3, 5,  10'd192, 9'd120, BG};
        vt[5] = '{1'b0, 1'b1, 1'b0, 4'd0, 5'd0,  9'h0AB, 0, 0,  10'd0,   9'd0,   9'h0AB};
        vt[6] = '{1'b0, 1'b1, 1'b0, 4'd0, 5'd0,  9'h0AB, 1, 0,  10'd64,  9'd0,   FG};
        vt[7] = '{1'b0, 1'b0, 1'b0, 4'd7, 5'd12, 9'h155, 7, 12, 10'd448, 9'd288, 9'h155};
        vt[8] = '{1'b0, 1'b0, 1'b0, 4'd7, 5'd12, 9'h155, 6, 12, 10'd384, 9'd288, BG};

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check_all_zero("reset");
        @(posedge CLOCK_50); #2 reset = 1'b0;

        // Latency, start count, single frame_done
        set_board(1'b0, 1'b0);
        blank = 1'b0; cur_x = 4'd3; cur_y = 5'd5; piece_color = 9'h0AB;
        base = total_starts;
        frames0 = frames;
        push_sweep();
        pulse_req();
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            check($sformatf("latency_cycle%0d", k), {31'd0, start}, {31'd0, k == 4});
            if (k == 1) check("sweeping_rises", {31'd0, sweeping}, 32'd1);
        end
        wait_frame("sweep1");
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check("sweeping_after_frame", {31'd0, sweeping}, 32'd0);
        check("starts_per_sweep", total_starts - base, 32'd200);
        check("frame_done_once", frames - frames0, 32'd1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        // Probe table
        for (int i = 0; i < 9; i++) begin
            set_board(vt[i].fill, vt[i].corner);
            blank = vt[i].bl; cur_x = vt[i].px; cur_y = vt[i].py; piece_color = vt[i].pc;
            push_sweep();
            pulse_req();
            wait_frame($sformatf("vec%0d", i));
            @(negedge CLOCK_50);
            check($sformatf("vec%0d_draw", i), {4'd0, cap[vt[i].cy * 10 + vt[i].cx]},
                  {4'd0, vt[i].ex0, vt[i].ey0, vt[i].ecol});
        end
        blank = 1'b0;

        // Random boards with inputs changed mid-sweep
        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < 10; x++)
                for (int y = 0; y < 20; y++)
                    occ[x][y] = bit'($urandom_range(0, 1));
            blank = ($urandom_range(0, 3) == 0);
            cur_x = 4'($urandom_range(0, 9));
            cur_y = 5'($urandom_range(0, 19));
            piece_color = 9'($urandom);
            push_sweep();
            pulse_req();
            repeat (150 + $urandom_range(0, 400)) @(posedge CLOCK_50);
            #2;
            cur_x = 4'($urandom_range(0, 9));
            cur_y = 5'($urandom_range(0, 19));
            piece_color = 9'($urandom);
            blank = ~blank;
            wait_frame($sformatf("rand%0d", r));
            @(negedge CLOCK_50);
            check($sformatf("rand%0d_drained", r), exp_q.size(), 32'd0);
        end
        blank = 1'b0;

        // Several reqs during a sweep yield exactly one extra sweep
        base = total_starts;
        frames0 = frames;
        push_sweep();
        push_sweep();
        pulse_req();
        repeat (300) @(posedge CLOCK_50);
        for (int j = 0; j < 3; j++) begin
            pulse_req();
            repeat (50) @(posedge CLOCK_50);
        end
        wait_frame("pend_a");
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check("pending_restart", {31'd0, sweeping}, 32'd1);
        wait_frame("pend_b");
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        check("pending_no_stack", {31'd0, sweeping}, 32'd0);
        repeat (30) @(negedge CLOCK_50);
        check("pending_starts", total_starts - base, 32'd400);
        check("pending_frames", frames - frames0, 32'd2);
        check("pending_drained", exp_q.size(), 32'd0);

        // req in the frame_done cycle
        push_sweep();
        pulse_req();
        wait_frame("fd_a");
        req = 1'b1;
        push_sweep();
        @(posedge CLOCK_50); #2 req = 1'b0;
        @(negedge CLOCK_50);
        check("req_at_frame_done", {31'd0, sweeping}, 32'd1);
        wait_frame("fd_b");
        @(negedge CLOCK_50);
        check("fd_drained", exp_q.size(), 32'd0);

        // busy held in LAUNCH with spurious done pulses
        base = total_starts;
        push_sweep();
        pulse_req();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLOCK_50); #1;
            if (rdone) found = 1'b1;
        end
        check("first_done_seen", {31'd0, found}, 32'd1);
        busy_hold = 1'b1;
        stray = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLOCK_50); #1;
            spur_done = (i % 9 == 4);
            if (start) stray++;
        end
        busy_hold = 1'b0;
        spur_done = 1'b0;
        check("start_low_while_busy", stray, 32'd0);
        @(negedge CLOCK_50);
        check("start_after_busy", {31'd0, start}, 32'd1);
        wait_frame("busy_sweep");
        @(negedge CLOCK_50);
        check("busy_sweep_starts", total_starts - base, 32'd200);
        check("busy_drained", exp_q.size(), 32'd0);

        // Reset mid-sweep at cell (4,7)
        push_sweep();
        pulse_req();
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge CLOCK_50);
            if (board_rx == 4'd4 && board_ry == 5'd7) found = 1'b1;
        end
        check("reached_cell_4_7", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        check_all_zero("abort");
        exp_q.delete();
        @(negedge CLOCK_50); reset = 1'b0;
        base = total_starts;
        repeat (100) @(negedge CLOCK_50);
        check("no_start_after_abort", total_starts - base, 32'd0);
        check("idle_after_abort", {31'd0, sweeping}, 32'd0);
        push_sweep();
        pulse_req();
        wait_frame("post_reset");
        @(negedge CLOCK_50);
        check("post_reset_starts", total_starts - base, 32'd200);
        check("post_reset_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
